// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB-Lite multi-master arbiter.
//   htrans_t / hburst_t : AHB transfer and burst encodings
//   addr_phase_t        : one complete address phase (address + control)
//   burst_len()         : beats in a burst (0 = undefined-length INCR)
//   is_active()         : HTRANS carries a real transfer (NONSEQ/SEQ)
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_t;

    // Address field is sized for the widest supported bus; the top
    // zero-extends narrower masters into it and slices back out.
    localparam int AP_AW = 64;

    typedef struct packed {
        logic [AP_AW-1:0] addr;
        htrans_t          trans;
        logic             write;
        logic [2:0]       size;
        hburst_t          burst;
        logic [3:0]       prot;
    } addr_phase_t;

    function automatic logic [4:0] burst_len(input hburst_t b);
        case (b)
            SINGLE:         return 5'd1;
            INCR:           return 5'd0;
            WRAP4, INCR4:   return 5'd4;
            WRAP8, INCR8:   return 5'd8;
            default:        return 5'd16;
        endcase
    endfunction

    function automatic logic is_active(input htrans_t t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

endpackage

// File: rtl/ahb_arb_input_stage.sv
// Per-master front end of the arbiter: one-entry holding register for a
// transfer that could not be forwarded, plus this master's HREADY/HRESP.
//   HCLK, HRESET    : bus clock, async active-high reset
//   i_live          : master's live address phase
//   i_is_aowner     : this master owns the address phase
//   i_dphase_mine   : the slave data phase in flight belongs to this master
//   i_s_hreadyout   : slave ready
//   i_s_hresp       : slave response
//   o_src           : request source (held entry if valid, else live)
//   o_req           : o_src carries NONSEQ/SEQ
//   o_hready        : HREADY returned to this master
//   o_hresp         : HRESP returned to this master
module ahb_arb_input_stage
    import ahb_arb_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  addr_phase_t i_live,
    input  logic        i_is_aowner,
    input  logic        i_dphase_mine,
    input  logic        i_s_hreadyout,
    input  logic        i_s_hresp,
    output addr_phase_t o_src,
    output logic        o_req,
    output logic        o_hready,
    output logic        o_hresp
);

    addr_phase_t r_pend;
    logic        r_pend_vld;
    logic        r_pend_reown;   // entry must win ownership before replay
    logic        w_cap;
    logic        w_clr;

    // A held entry that waited for ownership restarts as an undefined-length
    // burst: the slave never saw its predecessor beats in sequence.
    always_comb begin
        o_src = i_live;
        if (r_pend_vld) begin
            o_src = r_pend;
            if (r_pend_reown) begin
                o_src.trans = NONSEQ;
                o_src.burst = INCR;
            end
        end
    end

    assign o_req    = is_active(o_src.trans);
    assign o_hready = i_dphase_mine ? i_s_hreadyout : !r_pend_vld;
    assign o_hresp  = i_dphase_mine & i_s_hresp;

    // The owner with a ready slave is accepted directly; any other accepted
    // master request is parked so it is never lost.
    assign w_cap = o_hready && !r_pend_vld && is_active(i_live.trans) &&
                   !(i_is_aowner && i_s_hreadyout);
    assign w_clr = r_pend_vld && i_is_aowner && i_s_hreadyout;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_pend_vld   <= 1'b0;
            r_pend_reown <= 1'b0;
            r_pend       <= '0;
        end else if (w_clr) begin
            r_pend_vld   <= 1'b0;
        end else if (w_cap) begin
            r_pend_vld   <= 1'b1;
            r_pend       <= i_live;
            r_pend_reown <= !i_is_aowner;
        end
    end

endmodule

// File: rtl/ahb_lite_arbiter.sv
// Shares one AHB-Lite slave between NUM_M masters: round-robin address
// arbitration, fixed-length burst locking, per-master holding registers and
// data-phase routing to the master that owns the data phase.
//   HCLK, HRESET                 : clock, async active-high reset
//   M_* (packed, master i slice) : master address/control/write data in
//   M_HRDATA/M_HREADY/M_HRESP    : responses back to masters
//   S_*                          : forwarded slave bus and slave responses
//   GRANT                        : one-hot address-phase owner
module ahb_lite_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [NUM_M*AW-1:0] M_HADDR,
    input  logic [NUM_M*2-1:0]  M_HTRANS,
    input  logic [NUM_M-1:0]    M_HWRITE,
    input  logic [NUM_M*3-1:0]  M_HSIZE,
    input  logic [NUM_M*3-1:0]  M_HBURST,
    input  logic [NUM_M*4-1:0]  M_HPROT,
    input  logic [NUM_M*DW-1:0] M_HWDATA,
    output logic [DW-1:0]       M_HRDATA,
    output logic [NUM_M-1:0]    M_HREADY,
    output logic [NUM_M-1:0]    M_HRESP,
    output logic                S_HSEL,
    output logic [AW-1:0]       S_HADDR,
    output logic [1:0]          S_HTRANS,
    output logic                S_HWRITE,
    output logic [2:0]          S_HSIZE,
    output logic [2:0]          S_HBURST,
    output logic [3:0]          S_HPROT,
    output logic [DW-1:0]       S_HWDATA,
    output logic                S_HREADY,
    input  logic                S_HREADYOUT,
    input  logic                S_HRESP,
    input  logic [DW-1:0]       S_HRDATA,
    output logic [NUM_M-1:0]    GRANT
);

    localparam int OW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    logic [OW-1:0] r_aowner;
    logic [OW-1:0] r_downer;
    logic          r_dvalid;
    logic [4:0]    r_beat;

    addr_phase_t      w_live [NUM_M];
    addr_phase_t      w_src  [NUM_M];
    logic [NUM_M-1:0] w_req;
    addr_phase_t      w_fwd;
    logic [OW-1:0]    w_next_owner;
    logic             w_found;
    logic [4:0]       w_len;
    logic             w_fixed;
    logic [4:0]       w_beat_nxt;
    logic             w_lock;

    for (genvar g = 0; g < NUM_M; g++) begin : g_m
        assign w_live[g] = '{
            addr:  AP_AW'(M_HADDR[g*AW +: AW]),
            trans: htrans_t'(M_HTRANS[g*2 +: 2]),
            write: M_HWRITE[g],
            size:  M_HSIZE[g*3 +: 3],
            burst: hburst_t'(M_HBURST[g*3 +: 3]),
            prot:  M_HPROT[g*4 +: 4]
        };

        ahb_arb_input_stage u_in (
            .HCLK          (HCLK),
            .HRESET        (HRESET),
            .i_live        (w_live[g]),
            .i_is_aowner   (r_aowner == OW'(g)),
            .i_dphase_mine (r_dvalid && (r_downer == OW'(g))),
            .i_s_hreadyout (S_HREADYOUT),
            .i_s_hresp     (S_HRESP),
            .o_src         (w_src[g]),
            .o_req         (w_req[g]),
            .o_hready      (M_HREADY[g]),
            .o_hresp       (M_HRESP[g])
        );
    end

    if (AW < AP_AW) begin : g_addr_hi
        logic w_unused_addr_hi;
        assign w_unused_addr_hi = ^w_fwd.addr[AP_AW-1:AW];
    end

    // Owner goes straight through (no added latency); the forwarded bus is
    // held IDLE while reset is asserted.
    always_comb begin
        w_fwd = w_src[r_aowner];
        if (HRESET) w_fwd.trans = IDLE;
    end

    assign S_HADDR  = w_fwd.addr[AW-1:0];
    assign S_HTRANS = w_fwd.trans;
    assign S_HSEL   = (w_fwd.trans != IDLE);
    assign S_HWRITE = w_fwd.write;
    assign S_HSIZE  = w_fwd.size;
    assign S_HBURST = w_fwd.burst;
    assign S_HPROT  = w_fwd.prot;
    assign S_HREADY = S_HREADYOUT;
    assign M_HRDATA = S_HRDATA;
    assign S_HWDATA = M_HWDATA[int'(r_downer)*DW +: DW];
    assign GRANT    = NUM_M'(1) << r_aowner;

    // Lock decision looks at the beat being accepted on this edge, so the
    // last beat of a fixed burst already releases the bus.
    assign w_len   = burst_len(w_fwd.burst);
    assign w_fixed = (w_len > 5'd1);

    always_comb begin
        w_beat_nxt = r_beat;
        if (w_fwd.trans == NONSEQ)   w_beat_nxt = 5'd1;
        else if (w_fwd.trans == SEQ) w_beat_nxt = r_beat + 5'd1;
    end

    assign w_lock = (w_fwd.trans == BUSY) ||
                    (is_active(w_fwd.trans) && w_fixed && (w_beat_nxt < w_len));

    // Round-robin search starting after the current owner, ending on it.
    always_comb begin
        w_next_owner = r_aowner;
        w_found      = 1'b0;
        for (int k = 1; k <= NUM_M; k++) begin
            if (!w_found && w_req[(int'(r_aowner) + k) % NUM_M]) begin
                w_next_owner = OW'((int'(r_aowner) + k) % NUM_M);
                w_found      = 1'b1;
            end
        end
    end

    // Nothing moves during wait states, keeping the forwarded bus stable.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_aowner <= '0;
            r_downer <= '0;
            r_dvalid <= 1'b0;
            r_beat   <= '0;
        end else if (S_HREADYOUT) begin
            r_dvalid <= is_active(w_fwd.trans);
            r_downer <= r_aowner;
            if (!w_lock && (w_next_owner != r_aowner)) begin
                r_aowner <= w_next_owner;
                r_beat   <= '0;
            end else if (w_fixed && is_active(w_fwd.trans)) begin
                r_beat   <= w_beat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Directed bench for ahb_lite_arbiter with two masters and a small
// zero-wait memory slave whose ready/response the sequence controls.
module tb_ahb_lite_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic             HCLK = 1'b0;
    logic             HRESET = 1'b0;
    logic [NM*AW-1:0] M_HADDR = '0;
    logic [NM*2-1:0]  M_HTRANS = '0;
    logic [NM-1:0]    M_HWRITE = '0;
    logic [NM*3-1:0]  M_HSIZE = {3'b010, 3'b010};
    logic [NM*3-1:0]  M_HBURST = '0;
    logic [NM*4-1:0]  M_HPROT = {4'b0011, 4'b0011};
    logic [NM*DW-1:0] M_HWDATA = '0;
    logic [DW-1:0]    M_HRDATA;
    logic [NM-1:0]    M_HREADY;
    logic [NM-1:0]    M_HRESP;
    logic             S_HSEL;
    logic [AW-1:0]    S_HADDR;
    logic [1:0]       S_HTRANS;
    logic             S_HWRITE;
    logic [2:0]       S_HSIZE;
    logic [2:0]       S_HBURST;
    logic [3:0]       S_HPROT;
    logic [DW-1:0]    S_HWDATA;
    logic             S_HREADY;
    logic             S_HREADYOUT = 1'b1;
    logic             S_HRESP = 1'b0;
    logic [DW-1:0]    S_HRDATA;
    logic [NM-1:0]    GRANT;

    int n_chk  = 0;
    int n_fail = 0;

    ahb_lite_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE),
        .M_HSIZE(M_HSIZE), .M_HBURST(M_HBURST), .M_HPROT(M_HPROT),
        .M_HWDATA(M_HWDATA), .M_HRDATA(M_HRDATA), .M_HREADY(M_HREADY),
        .M_HRESP(M_HRESP), .S_HSEL(S_HSEL), .S_HADDR(S_HADDR),
        .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
        .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HWDATA(S_HWDATA),
        .S_HREADY(S_HREADY), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
        .S_HRDATA(S_HRDATA), .GRANT(GRANT)
    );

    always #5 HCLK = ~HCLK;

    // Memory slave: address phase registered on a ready edge, write data
    // committed on the ready edge that closes the data phase.
    logic [31:0] mem [0:255];
    logic        dp_vld;
    logic        dp_wr;
    logic [7:0]  dp_a;

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_vld <= 1'b0;
        end else if (S_HREADY) begin
            if (dp_vld && dp_wr) mem[dp_a] <= S_HWDATA;
            dp_vld <= S_HSEL && S_HTRANS[1];
            dp_a   <= S_HADDR[9:2];
            dp_wr  <= S_HWRITE;
        end
    end

    assign S_HRDATA = (dp_vld && !dp_wr) ? mem[dp_a] : 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int m, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic [2:0] bu);
        M_HTRANS[m*2 +: 2]  = tr;
        M_HADDR[m*AW +: AW] = a;
        M_HWRITE[m]         = wr;
        M_HBURST[m*3 +: 3]  = bu;
    endtask

    task automatic wdat(input int m, input logic [31:0] d);
        M_HWDATA[m*DW +: DW] = d;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    task automatic nxt();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset: live owner request must not reach the slave.
        drv(0, 2'b10, 32'h10, 1'b1, 3'd0);
        #1 HRESET = 1'b1;
        #2;
        chk("rst_htrans", S_HTRANS, 2'b00);
        chk("rst_hsel",   S_HSEL,   1'b0);
        chk("rst_grant",  GRANT,    2'b01);
        chk("rst_hready", M_HREADY, 2'b11);
        chk("rst_hresp",  M_HRESP,  2'b00);
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0);
        @(posedge HCLK);
        @(posedge HCLK);
        #1 HRESET = 1'b0;

        // M0 SINGLE write, M1 idle: zero-latency forward.
        drv(0, 2'b10, 32'h10, 1'b1, 3'd0);
        mid();
        chk("t1_haddr",  S_HADDR,  32'h10);
        chk("t1_htrans", S_HTRANS, 2'b10);
        chk("t1_hsel",   S_HSEL,   1'b1);
        chk("t1_hwrite", S_HWRITE, 1'b1);
        chk("t1_hsize",  S_HSIZE,  3'b010);
        chk("t1_hprot",  S_HPROT,  4'b0011);
        nxt();
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0);
        wdat(0, 32'hA5A50001);
        mid();
        chk("t1_hready", M_HREADY, 2'b11);
        chk("t1_hwdata", S_HWDATA, 32'hA5A50001);
        nxt();

        // Simultaneous requests: M0 forwarded, M1 parked then replayed.
        drv(0, 2'b10, 32'h20, 1'b1, 3'd0);
        drv(1, 2'b10, 32'h10, 1'b0, 3'd0);
        mid();
        chk("t1_mem",     mem[4],   32'hA5A50001);
        chk("t2_haddr0",  S_HADDR,  32'h20);
        chk("t2_grant0",  GRANT,    2'b01);
        chk("t2_hready0", M_HREADY, 2'b11);
        nxt();
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0);
        wdat(0, 32'h11112222);
        drv(1, 2'b00, 32'h0, 1'b0, 3'd0);
        mid();
        chk("t2_grant1",  GRANT,    2'b10);
        chk("t2_haddr1",  S_HADDR,  32'h10);
        chk("t2_htrans1", S_HTRANS, 2'b10);
        chk("t2_hwrite1", S_HWRITE, 1'b0);
        chk("t2_hready1", M_HREADY, 2'b01);
        chk("t2_hwdata",  S_HWDATA, 32'h11112222);
        nxt();
        S_HREADYOUT = 1'b0;
        mid();
        chk("t2_hready_wait", M_HREADY, 2'b01);
        chk("t2_hsel_idle",   S_HSEL,   1'b0);
        nxt();
        S_HREADYOUT = 1'b1;
        mid();
        chk("t2_hready_done", M_HREADY, 2'b11);
        chk("t2_hrdata",      M_HRDATA, 32'hA5A50001);
        nxt();

        // M0 regains ownership through its held entry (replayed as INCR).
        drv(0, 2'b10, 32'h20, 1'b0, 3'd0);
        mid();
        chk("g_grant_m1", GRANT,    2'b10);
        chk("g_htrans",   S_HTRANS, 2'b00);
        nxt();
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0);
        mid();
        chk("g_grant_m0", GRANT,    2'b01);
        chk("g_haddr",    S_HADDR,  32'h20);
        chk("g_hburst",   S_HBURST, 3'd1);
        chk("g_htrans2",  S_HTRANS, 2'b10);
        chk("g_hready",   M_HREADY, 2'b10);
        nxt();
        mid();
        chk("g_hready2",  M_HREADY, 2'b11);
        chk("g_hrdata",   M_HRDATA, 32'h11112222);
        nxt();

        // M0 INCR4 locked against a competing M1 request.
        drv(0, 2'b10, 32'h100, 1'b1, 3'd3);
        drv(1, 2'b10, 32'h200, 1'b1, 3'd0);
        mid();
        chk("t3_haddr_b1", S_HADDR, 32'h100);
        chk("t3_grant_b1", GRANT,   2'b01);
        nxt();
        drv(0, 2'b11, 32'h104, 1'b1, 3'd3);
        wdat(0, 32'hD0D0_0100);
        drv(1, 2'b00, 32'h0, 1'b0, 3'd0);
        mid();
        chk("t3_haddr_b2",  S_HADDR,  32'h104);
        chk("t3_grant_b2",  GRANT,    2'b01);
        chk("t3_hready_b2", M_HREADY, 2'b01);
        nxt();
        drv(0, 2'b11, 32'h108, 1'b1, 3'd3);
        wdat(0, 32'hD1D1_0104);
        mid();
        chk("t3_haddr_b3", S_HADDR, 32'h108);
        chk("t3_grant_b3", GRANT,   2'b01);
        nxt();
        drv(0, 2'b11, 32'h10C, 1'b1, 3'd3);
        wdat(0, 32'hD2D2_0108);
        mid();
        chk("t3_haddr_b4",  S_HADDR,  32'h10C);
        chk("t3_htrans_b4", S_HTRANS, 2'b11);
        chk("t3_grant_b4",  GRANT,    2'b01);
        nxt();
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0);
        wdat(0, 32'hD3D3_010C);

        // Three wait states while M1's held entry is forwarded.
        S_HREADYOUT = 1'b0;
        for (int w = 0; w < 3; w++) begin
            mid();
            chk("t4_grant",  GRANT,    2'b10);
            chk("t4_haddr",  S_HADDR,  32'h200);
            chk("t4_htrans", S_HTRANS, 2'b10);
            chk("t4_hready", M_HREADY, 2'b00);
            nxt();
        end
        S_HREADYOUT = 1'b1;
        mid();
        chk("t4_hready_end", M_HREADY, 2'b01);
        chk("t4_hwdata_b4",  S_HWDATA, 32'hD3D3_010C);
        nxt();
        wdat(1, 32'hCAFE0200);
        mid();
        chk("t4_hwdata_m1", S_HWDATA, 32'hCAFE0200);
        chk("t4_hready_m1", M_HREADY, 2'b11);
        nxt();

        // Slave ERROR on an M0 read.
        drv(0, 2'b10, 32'h30, 1'b0, 3'd0);
        mid();
        chk("t3_mem0", mem[64],  32'hD0D0_0100);
        chk("t3_mem1", mem[65],  32'hD1D1_0104);
        chk("t3_mem2", mem[66],  32'hD2D2_0108);
        chk("t3_mem3", mem[67],  32'hD3D3_010C);
        chk("t4_mem",  mem[128], 32'hCAFE0200);
        nxt();
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0);
        mid();
        chk("t5_grant", GRANT,   2'b01);
        chk("t5_haddr", S_HADDR, 32'h30);
        nxt();
        S_HREADYOUT = 1'b0;
        S_HRESP     = 1'b1;
        mid();
        chk("t5_hresp_c1",  M_HRESP,  2'b01);
        chk("t5_hready_c1", M_HREADY, 2'b10);
        nxt();
        S_HREADYOUT = 1'b1;
        mid();
        chk("t5_hresp_c2",  M_HRESP,  2'b01);
        chk("t5_hready_c2", M_HREADY, 2'b11);
        nxt();
        S_HRESP = 1'b0;

        // Reset pulse during INCR4 beat 2 with M1 held.
        drv(0, 2'b10, 32'h140, 1'b1, 3'd3);
        drv(1, 2'b10, 32'h10, 1'b0, 3'd0);
        mid();
        chk("t6_hresp_clr", M_HRESP, 2'b00);
        chk("t6_grant",     GRANT,   2'b01);
        nxt();
        drv(0, 2'b11, 32'h144, 1'b1, 3'd3);
        wdat(0, 32'hBEEF0140);
        drv(1, 2'b00, 32'h0, 1'b0, 3'd0);
        mid();
        chk("t6_haddr_b2",  S_HADDR,  32'h144);
        chk("t6_hready_b2", M_HREADY, 2'b01);
        #2 HRESET = 1'b1;
        #1;
        chk("t6_rst_htrans", S_HTRANS, 2'b00);
        chk("t6_rst_hsel",   S_HSEL,   1'b0);
        chk("t6_rst_grant",  GRANT,    2'b01);
        chk("t6_rst_hready", M_HREADY, 2'b11);
        chk("t6_rst_hresp",  M_HRESP,  2'b00);
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0);
        nxt();
        HRESET = 1'b0;
        drv(0, 2'b10, 32'h40, 1'b1, 3'd0);
        mid();
        chk("t6_post_haddr",  S_HADDR,  32'h40);
        chk("t6_post_htrans", S_HTRANS, 2'b10);
        nxt();
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0);
        wdat(0, 32'h5555AAAA);
        mid();
        chk("t6_post_hwdata", S_HWDATA, 32'h5555AAAA);
        chk("t6_post_hready", M_HREADY, 2'b11);
        nxt();
        mid();
        chk("t6_post_mem",   mem[16], 32'h5555AAAA);
        chk("t6_dropped_b1", mem[80], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_lite_arbiter.md
Name: ahb_lite_arbiter

Overview:
- Shares one AHB-Lite slave (the memory) between NUM_M AHB-Lite masters (DUT side of the memory bench).
- Round-robin address-phase arbitration, fixed-length burst locking, and a one-entry holding register per master so a non-owner's transfer is never lost.
- Routes slave HRDATA/HRESP/HREADYOUT to the master owning the data phase, and that master's HWDATA to the slave.

Parameters:
NUM_M, 2, number of masters (2..4)
AW, 32, address width
DW, 32, data width

Ports:
HCLK  in  1  bus clock
HRESET  in  1  asynchronous active-high reset
M_HADDR  in  NUM_M*AW  master addresses, master i at [i*AW +: AW]
M_HTRANS  in  NUM_M*2  master transfer types
M_HWRITE  in  NUM_M  master directions
M_HSIZE  in  NUM_M*3  master sizes
M_HBURST  in  NUM_M*3  master burst types
M_HPROT  in  NUM_M*4  master protection
M_HWDATA  in  NUM_M*DW  master write data
M_HRDATA  out  DW  read data, broadcast to all masters
M_HREADY  out  NUM_M  per-master HREADY
M_HRESP  out  NUM_M  per-master HRESP
S_HSEL, S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT, S_HWDATA  out  1/AW/2/1/3/3/4/DW  forwarded slave bus
S_HREADY  out  1  slave HREADY input, equal to S_HREADYOUT
S_HREADYOUT  in  1  slave ready
S_HRESP  in  1  slave response
S_HRDATA  in  DW  slave read data
GRANT  out  NUM_M  one-hot address-phase owner (aowner)

Behaviour:
- Reset (HRESET=1, asynchronous):
  - pending[] cleared; aowner=0, so GRANT=...01.
  - dvalid=0, lock=0, beat=0.
  - Outputs: S_HTRANS=IDLE, S_HSEL=0, M_HREADY all 1, M_HRESP all 0.
  - Any in-flight transfer is dropped.
- Request source for master i: pending[i] if valid, else the live M_* inputs.
- Forwarded bus: aowner's request source.
  - S_HSEL = (S_HTRANS != IDLE).
  - A non-owner sees nothing forwarded.
- Zero added latency for the owner.
- M_HREADY[i]:
  - S_HREADYOUT if dvalid and downer==i;
  - else 0 if pending[i] valid;
  - else 1.
- M_HRESP[i]: S_HRESP if dvalid and downer==i, else 0.
- Capture rule, applied at a rising edge with M_HREADY[i]=1 and live M_HTRANS[i] in {NONSEQ,SEQ}:
  - i==aowner and S_HREADYOUT=1: transfer accepted directly.
  - Otherwise: all address-phase fields loaded into pending[i].
  - IDLE and BUSY are never captured.
- While pending[i] is valid, master i's live inputs are ignored; the master is stalled by M_HREADY[i]=0.
- Pending replay after an ownership change: forwarded with HTRANS=NONSEQ and HBURST=INCR.
- Edge with S_HREADYOUT=1:
  - dvalid <= forwarded HTRANS in {NONSEQ,SEQ}; downer <= aowner.
  - pending[aowner] cleared if it was the source.
- Lock and burst counting:
  - beat counts accepted beats of a fixed-length burst (INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16).
  - lock=1 while the owner's forwarded transfer is BUSY, or NONSEQ/SEQ of a fixed-length burst with beat < length.
  - SINGLE and INCR never lock; switching may occur between INCR beats.
- Arbitration at an edge with S_HREADYOUT=1 and lock=0:
  - next aowner = first requester (pending valid, or live NONSEQ/SEQ) searching aowner+1, aowner+2, ... modulo NUM_M, ending at aowner itself.
  - No requester: aowner parks unchanged.
  - beat resets when aowner changes.
- aowner, lock and beat never change while S_HREADYOUT=0, so forwarded address/control stay stable across wait states.
- Data-phase routing: S_HWDATA = M_HWDATA[downer]. The master holds HWDATA because its HREADY is low until its data phase completes.
- ERROR (S_HRESP=1):
  - Both cycles routed only to downer.
  - The pending entry of that master is not discarded and still executes.
- Simultaneous events:
  - A master may complete a data phase and be captured into pending on the same edge.
  - Direct acceptance has priority over capture only for aowner.

Decomposition:
- Package ahb_arb_pkg:
  - htrans_t enum (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3);
  - hburst_t enum (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16);
  - addr_phase_t struct (addr, trans, write, size, burst, prot);
  - function burst_len(hburst_t) returning 1/0/4/8/16.
- Sub-module ahb_arb_input_stage, instantiated NUM_M times: pending register, capture logic, M_HREADY/M_HRESP generation, request-source mux.

Test Plan:
- M0 SINGLE write 0x10, data 0xA5A50001, M1 IDLE -> S_HADDR=0x10 in the same cycle; memory at 0x10 reads 0xA5A50001; M_HREADY[1] stays 1.
- M0 and M1 both NONSEQ SINGLE in the same cycle, aowner=0 -> M0 forwarded, M1 captured; M1 read forwarded the following cycle; M_HREADY[1] low ≥2 cycles, then 1 with S_HRDATA.
- M0 INCR4 at 0x100 while M1 requests -> beats 0x100/104/108/10C forwarded uninterrupted; GRANT=10 after beat 4 is accepted.
- S_HREADYOUT held 0 for 3 cycles while M1 pending -> S_HADDR/S_HTRANS/GRANT stable across all 3 cycles.
- Slave ERROR on M0 data phase (HRESP=1 with HREADYOUT 0 then 1) -> M_HRESP[0]=1 both cycles; M_HREADY[0] 0 then 1; M_HRESP[1]=0.
- HRESET pulsed during INCR4 beat 2 -> outputs return to reset values immediately; pending cleared; GRANT=01; first post-reset transfer succeeds.
